traffic_intersection_ctrl: RTL and testbench

Parametrised two-approach intersection controller driving main-road (A) and side-road (B) signal heads, a pedestrian walk lamp and a countdown seven-segment display. It replaces the single-head fixed-timing light controller with these additions:

- All phase durations are parameters, counted in seconds ticks from a built-in clock prescaler.
- A latched pedestrian request with acknowledge.
- A night (blinking-yellow) mode.
- A countdown display for every timed state.

---
 rtl/traffic_intersection_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller with pedestrian phase, night blinking
// mode and a countdown seven-segment display; all timing in prescaled ticks.
module traffic_intersection_ctrl #(
  parameter int TICK_DIV      = 4,
  parameter int CNT_W         = 8,
  parameter int T_IDLE        = 6,
  parameter int T_RED_YELLOW  = 2,
  parameter int T_GREEN_A     = 10,
  parameter int T_GREEN_B     = 6,
  parameter int T_GREEN_BLINK = 4,
  parameter int T_YELLOW      = 3,
  parameter int T_ALL_RED     = 1,
  parameter int T_WALK        = 5,
  parameter int BLINK_HALF    = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             night_mode,
  input  logic             ped_req,
  output logic             ped_ack,
  output logic             ped_walk,
  output logic             a_red,
  output logic             a_yellow,
  output logic             a_green,
  output logic             b_red,
  output logic             b_yellow,
  output logic             b_green,
  output logic [3:0]       cur_state,
  output logic [CNT_W-1:0] remaining,
  output logic [6:0]       seven_seg
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_A_RY  = 4'd1;
  localparam logic [3:0] S_A_G   = 4'd2;
  localparam logic [3:0] S_A_GB  = 4'd3;
  localparam logic [3:0] S_A_Y   = 4'd4;
  localparam logic [3:0] S_AR1   = 4'd5;
  localparam logic [3:0] S_B_RY  = 4'd6;
  localparam logic [3:0] S_B_G   = 4'd7;
  localparam logic [3:0] S_B_GB  = 4'd8;
  localparam logic [3:0] S_B_Y   = 4'd9;
  localparam logic [3:0] S_AR2   = 4'd10;
  localparam logic [3:0] S_PED   = 4'd11;
  localparam logic [3:0] S_NIGHT = 4'd12;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] elapsed;
  logic             ped_pending;
  logic             tick;
  logic             expire;
  logic             blink;
  logic             ped_entry;
  logic [3:0]       next_state;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] blink_phase;
  logic [3:0]       digit;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // NIGHT and illegal codes have no duration (dur = 0)
  always_comb begin
    dur = '0;
    case (cur_state)
      S_IDLE:         dur = CNT_W'(T_IDLE);
      S_A_RY, S_B_RY: dur = CNT_W'(T_RED_YELLOW);
      S_A_G:          dur = CNT_W'(T_GREEN_A);
      S_B_G:          dur = CNT_W'(T_GREEN_B);
      S_A_GB, S_B_GB: dur = CNT_W'(T_GREEN_BLINK);
      S_A_Y, S_B_Y:   dur = CNT_W'(T_YELLOW);
      S_AR1, S_AR2:   dur = CNT_W'(T_ALL_RED);
      S_PED:          dur = CNT_W'(T_WALK);
      default:        dur = '0;
    endcase
  end

  assign expire = tick && (dur != '0) && (elapsed == dur - CNT_W'(1));

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      S_IDLE:  if (expire) next_state = S_A_RY;
      S_A_RY:  if (expire) next_state = S_A_G;
      S_A_G:   if (expire) next_state = S_A_GB;
      S_A_GB:  if (expire) next_state = S_A_Y;
      S_A_Y:   if (expire) next_state = S_AR1;
      S_AR1:   if (expire) next_state = night_mode ? S_NIGHT : S_B_RY;
      S_B_RY:  if (expire) next_state = S_B_G;
      S_B_G:   if (expire) next_state = S_B_GB;
      S_B_GB:  if (expire) next_state = S_B_Y;
      S_B_Y:   if (expire) next_state = S_AR2;
      S_AR2:   if (expire) next_state = night_mode  ? S_NIGHT :
                                        ped_pending ? S_PED   : S_A_RY;
      S_PED:   if (expire) next_state = S_A_RY;
      S_NIGHT: if (tick && !night_mode) next_state = S_AR2;
      default: next_state = S_IDLE;
    endcase
  end

  assign ped_entry = (next_state == S_PED) && (cur_state != S_PED);

  // Prescaler and elapsed restart on every state change; NIGHT wraps elapsed
  // over one blink period since it has no duration of its own.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_state   <= S_IDLE;
      presc       <= '0;
      elapsed     <= '0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      cur_state <= next_state;
      if (next_state != cur_state) begin
        presc   <= '0;
        elapsed <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (cur_state == S_NIGHT && elapsed == CNT_W'(2 * BLINK_HALF - 1))
            elapsed <= '0;
          else
            elapsed <= elapsed + CNT_W'(1);
        end
      end
      if (ped_entry)
        ped_pending <= 1'b0;
      else if (ped_req)
        ped_pending <= 1'b1;
      ped_ack <= ped_req && !ped_pending && !ped_entry;
    end
  end

  assign blink_phase = (elapsed / CNT_W'(BLINK_HALF)) % CNT_W'(2);
  assign blink       = (blink_phase == '0);

  always_comb begin
    a_red    = 1'b0;
    a_yellow = 1'b0;
    a_green  = 1'b0;
    b_red    = 1'b0;
    b_yellow = 1'b0;
    b_green  = 1'b0;
    ped_walk = 1'b0;
    case (cur_state)
      S_IDLE, S_NIGHT: begin a_yellow = blink; b_yellow = blink; end
      S_A_RY:  begin a_red = 1'b1; a_yellow = 1'b1; b_red = 1'b1; end
      S_A_G:   begin a_green = 1'b1; b_red = 1'b1; end
      S_A_GB:  begin a_green = blink; b_red = 1'b1; end
      S_A_Y:   begin a_yellow = 1'b1; b_red = 1'b1; end
      S_AR1, S_AR2: begin a_red = 1'b1; b_red = 1'b1; end
      S_B_RY:  begin b_red = 1'b1; b_yellow = 1'b1; a_red = 1'b1; end
      S_B_G:   begin b_green = 1'b1; a_red = 1'b1; end
      S_B_GB:  begin b_green = blink; a_red = 1'b1; end
      S_B_Y:   begin b_yellow = 1'b1; a_red = 1'b1; end
      S_PED:   begin a_red = 1'b1; b_red = 1'b1; ped_walk = 1'b1; end
      default: ;
    endcase
  end

  assign remaining = (dur != '0) ? dur - elapsed : '0;
  assign digit     = (remaining > CNT_W'(9)) ? 4'd9 : remaining[3:0];

  always_comb begin
    seven_seg = 7'b0000000;
    if (cur_state != S_NIGHT) begin
      case (digit)
        4'd0:    seven_seg = 7'b0111111;
        4'd1:    seven_seg = 7'b0000110;
        4'd2:    seven_seg = 7'b1011011;
        4'd3:    seven_seg = 7'b1001111;
        4'd4:    seven_seg = 7'b1100110;
        4'd5:    seven_seg = 7'b1101101;
        4'd6:    seven_seg = 7'b1111101;
        4'd7:    seven_seg = 7'b0000111;
        4'd8:    seven_seg = 7'b1111111;
        default: seven_seg = 7'b1101111;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Table-driven bench for traffic_intersection_ctrl: per-cycle expected outputs
// built from phase durations, plus a hand-written pedestrian sequence.
module tb_traffic_intersection_ctrl;

  localparam int TDIV = 2;
  localparam int CW   = 8;
  localparam int TI   = 3;
  localparam int TRY  = 2;
  localparam int TGA  = 5;
  localparam int TGB  = 4;
  localparam int TGBL = 4;
  localparam int TY   = 2;
  localparam int TAR  = 1;
  localparam int TW   = 3;
  localparam int BH   = 1;
  localparam int MAXV = 512;

  typedef struct {
    logic          rst_n;
    logic          night;
    logic          req;
    logic [3:0]    st;
    logic [6:0]    lamps;
    logic [CW-1:0] rem;
    logic [6:0]    seg;
    logic          ack;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          night_mode;
  logic          ped_req;
  logic          ped_ack;
  logic          ped_walk;
  logic          a_red, a_yellow, a_green;
  logic          b_red, b_yellow, b_green;
  logic [3:0]    cur_state;
  logic [CW-1:0] remaining;
  logic [6:0]    seven_seg;

  vec_t vecs [MAXV];
  int   nvec;
  int   ph_start [16];
  logic g_rst;
  logic g_night;
  int   n_cmp;
  int   n_fail;

  traffic_intersection_ctrl #(
    .TICK_DIV(TDIV), .CNT_W(CW), .T_IDLE(TI), .T_RED_YELLOW(TRY),
    .T_GREEN_A(TGA), .T_GREEN_B(TGB), .T_GREEN_BLINK(TGBL), .T_YELLOW(TY),
    .T_ALL_RED(TAR), .T_WALK(TW), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .resetn(resetn), .night_mode(night_mode), .ped_req(ped_req),
    .ped_ack(ped_ack), .ped_walk(ped_walk),
    .a_red(a_red), .a_yellow(a_yellow), .a_green(a_green),
    .b_red(b_red), .b_yellow(b_yellow), .b_green(b_green),
    .cur_state(cur_state), .remaining(remaining), .seven_seg(seven_seg)
  );

  always #5 clk = ~clk;

  function automatic int dur_of(int st);
    case (st)
      0:       return TI;
      1, 6:    return TRY;
      2:       return TGA;
      7:       return TGB;
      3, 8:    return TGBL;
      4, 9:    return TY;
      5, 10:   return TAR;
      11:      return TW;
      default: return 0;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      default: return 7'b1101111;
    endcase
  endfunction

  // Lamp order {a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk}
  function automatic logic [6:0] lamps_of(int st, int c);
    logic b;
    b = (((c / TDIV) / BH) % 2) == 0;
    case (st)
      0, 12:   return {1'b0, b, 1'b0, 1'b0, b, 1'b0, 1'b0};
      1:       return 7'b1101000;
      2:       return 7'b0011000;
      3:       return {1'b0, 1'b0, b, 1'b1, 1'b0, 1'b0, 1'b0};
      4:       return 7'b0101000;
      5, 10:   return 7'b1001000;
      6:       return 7'b1001100;
      7:       return 7'b1000010;
      8:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, b, 1'b0};
      9:       return 7'b1000100;
      11:      return 7'b1001001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic void add_cycles(int st, int first_c, int n);
    int c;
    int r;
    if (first_c == 0) ph_start[st] = nvec;
    for (int k = 0; k < n; k++) begin
      c = first_c + k;
      vecs[nvec].rst_n = g_rst;
      vecs[nvec].night = g_night;
      vecs[nvec].req   = 1'b0;
      vecs[nvec].st    = 4'(st);
      vecs[nvec].lamps = lamps_of(st, c);
      vecs[nvec].ack   = 1'b0;
      if (st == 12) begin
        vecs[nvec].rem = '0;
        vecs[nvec].seg = 7'b0000000;
      end else begin
        r = dur_of(st) - c / TDIV;
        vecs[nvec].rem = CW'(r);
        vecs[nvec].seg = seg_of((r > 9) ? 9 : r);
      end
      nvec++;
    end
  endfunction

  function automatic void add_phase(int st);
    add_cycles(st, 0, dur_of(st) * TDIV);
  endfunction

  function automatic void add_full_cycle();
    for (int s = 1; s <= 10; s++) add_phase(s);
  endfunction

  function automatic void mark_req(int idx, logic acked);
    vecs[idx].req = 1'b1;
    if (acked) vecs[idx + 1].ack = 1'b1;
  endfunction

  task automatic apply_stimulus(input vec_t v);
    resetn     = v.rst_n;
    night_mode = v.night;
    ped_req    = v.req;
  endtask

  task automatic check_output(input string name, input int idx,
                              input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int budget;
    int walk_cnt;
    int guard;

    n_cmp   = 0;
    n_fail  = 0;
    nvec    = 0;
    g_night = 1'b0;
    for (int s = 0; s < 16; s++) ph_start[s] = 0;

    // Reset, release, start-up blinking and a request-free cycle
    g_rst = 1'b0;
    add_cycles(0, 0, 1);
    g_rst = 1'b1;
    add_phase(0);
    add_full_cycle();

    // Request during A_G, then a second request during PED
    add_full_cycle();
    mark_req(ph_start[2] + 3, 1'b1);
    add_phase(11);
    mark_req(ph_start[11] + 2, 1'b1);

    // Request on the PED entry cycle is absorbed; next cycle has no PED
    add_full_cycle();
    mark_req(ph_start[10] + TAR * TDIV - 1, 1'b0);
    add_phase(11);
    add_full_cycle();

    // Night mode raised in B_G, request during NIGHT, then leave NIGHT
    add_full_cycle();
    for (int k = ph_start[7] + 2; k < nvec; k++) vecs[k].night = 1'b1;
    g_night = 1'b1;
    add_cycles(12, 0, 8);
    mark_req(ph_start[12] + 4, 1'b1);
    g_night = 1'b0;
    add_cycles(12, 8, 2);
    add_phase(10);

    // Reset in the middle of PED with a fresh request latched
    add_cycles(11, 0, 3);
    mark_req(ph_start[11] + 1, 1'b1);
    vecs[nvec - 1].rst_n = 1'b0;
    add_phase(0);
    add_full_cycle();
    add_cycles(1, 0, 1);

    resetn     = 1'b0;
    night_mode = 1'b0;
    ped_req    = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < nvec; i++) begin
      @(posedge clk);
      #1;
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output("state", i, 16'(cur_state), 16'(vecs[i].st));
      check_output("lamps", i,
                   16'({a_red, a_yellow, a_green, b_red, b_yellow, b_green, ped_walk}),
                   16'(vecs[i].lamps));
      check_output("remaining", i, 16'(remaining), 16'(vecs[i].rem));
      check_output("seven_seg", i, 16'(seven_seg), 16'(vecs[i].seg));
      check_output("ped_ack", i, 16'(ped_ack), 16'(vecs[i].ack));
    end

    // Hand sequence: request in IDLE is served after the first AR2
    @(posedge clk);
    #1;
    resetn     = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    ped_req = 1'b1;
    @(posedge clk);
    #1;
    ped_req = 1'b0;
    @(negedge clk);
    check_output("hand_ack_high", 0, 16'(ped_ack), 16'd1);
    @(negedge clk);
    check_output("hand_ack_low", 0, 16'(ped_ack), 16'd0);

    budget = 0;
    while (cur_state != 4'd11 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_output("hand_ped_reached", 0, 16'(cur_state), 16'd11);

    walk_cnt = 0;
    guard    = 0;
    while (cur_state == 4'd11 && guard < 50) begin
      if (ped_walk) walk_cnt++;
      guard++;
      @(negedge clk);
    end
    check_output("hand_walk_cycles", 0, 16'(walk_cnt), 16'(TW * TDIV));
    check_output("hand_after_ped", 0, 16'(cur_state), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
